uart_rx: RTL and testbench
==========================

# uart_rx

Serial receiver that turns the PC's UART line into the byte strobe consumed by the snake game core. Sits between the board RX pin and the `snake` block's `dataRX`/`WR_RX` inputs, in the `px_clk` domain.

- Direction commands arrive as ASCII 65–68.
- Output is a one-cycle write strobe plus a held data byte.

## Interface
Parameters:
- `CLK_FREQ`, 31500000, `px_clk` frequency in Hz.
- `BAUD`, 115200, line rate in bit/s.
- `CLKS_PER_BIT`, `CLK_FREQ/BAUD` (integer divide, 273 at defaults), clocks per bit. Must be ≥ 8.

Ports:
- `px_clk`, input, 1, single clock. Rising edge only.
- `rstn`, input, 1, asynchronous active-low reset.
- `rx`, input, 1, asynchronous serial line. Idle high; 8N1 (8E1 with parity compiled in).
- `dataRX`, output, 8, last correctly received byte, LSB-first on the wire.
- `WR_RX`, output, 1, one-cycle pulse when `dataRX` has just been updated.
- `frame_err`, output, 1, one-cycle pulse on stop-bit (or parity) failure.
- `busy`, output, 1, high whenever the FSM is not in IDLE.

## Operation
- `rx` passes through a 2-FF synchronizer; both FFs reset to 1. All logic uses the synchronized `rxs`.
- Bit counter `bit_cnt` is 3 bits. Clock counter `clk_cnt` is `$clog2(CLKS_PER_BIT)` bits and is cleared on every state entry.
- IDLE: wait for `rxs` == 0 → START.
- START: at `clk_cnt == CLKS_PER_BIT/2 - 1`, sample `rxs`.
  - Sample 0 → DATA.
  - Sample 1 → IDLE (glitch rejected, no flags).
- DATA: every `CLKS_PER_BIT` clocks, shift `rxs` into a shift register MSB-side, so the first bit ends in bit 0. After the 8th sample, go to PARITY (macro defined) or STOP.
- PARITY: sample one bit after `CLKS_PER_BIT`. Store the mismatch against even parity → STOP.
- STOP: sample after `CLKS_PER_BIT`.
  - Sample 1 and no parity mismatch: load `dataRX` from the shift register, pulse `WR_RX` → IDLE.
  - Sample 0: pulse `frame_err` → BREAK.
  - Sample 1 with parity mismatch: pulse `frame_err` → IDLE.
- BREAK: wait for `rxs` == 1 → IDLE. Prevents a held-low line from being decoded as 0x00 bytes.
- `dataRX` holds its value until the next good frame. A failed frame never alters it.
- `WR_RX` and `frame_err` are never high in the same cycle.
- Reset asserted mid-frame discards the frame immediately; no strobe is issued.
- A new start edge seen in IDLE in the same cycle STOP returns is legal: a back-to-back frame with zero extra idle is received.

## Timing
- Reset values: `dataRX` = 0, `WR_RX` = 0, `frame_err` = 0, `busy` = 0, FSM = IDLE.
- Let T0 be the cycle in which `rxs` is first seen low in IDLE.
  - Start sample: T0 + `CLKS_PER_BIT/2`.
  - Data bit k (0..7): T0 + `CLKS_PER_BIT/2` + (k+1)·`CLKS_PER_BIT`.
  - Stop sample: data-bit-7 sample + `CLKS_PER_BIT` (+ `CLKS_PER_BIT` more with parity).
- `WR_RX`/`frame_err` are registered outputs, high during the cycle after the stop sample, for exactly 1 cycle.
- `dataRX` changes in that same cycle.
- Pin-to-`rxs` latency is 2 cycles, in addition to the above.
- Tolerates ±2 % baud mismatch at defaults.

## Configuration
- `UART_RX_PARITY_EN` defined: 8E1 framing, PARITY state present. A parity error gives `frame_err` and no `WR_RX`.
- Not defined: 8N1 framing, PARITY state and parity logic absent, no parity checking.

## Structure
- Package `uart_pkg`: FSM state typedef (IDLE, START, DATA, PARITY, STOP, BREAK), default `BAUD` constant, and a function computing `CLKS_PER_BIT`.
- One natural sub-module: `uart_rx_sync`, the 2-FF synchronizer with reset-to-1. The FSM and counters stay in `uart_rx`.

## Test plan
All at defaults, `CLKS_PER_BIT` = 273.
- Send 0x41 ('A'), 8N1 → exactly one `WR_RX` pulse, `dataRX` = 0x41, `frame_err` never high; pulse at the cycle predicted in Timing ±0.
- Send 0x43 then 0x44 back-to-back with no idle gap → two `WR_RX` pulses 2730 clocks apart, `dataRX` = 0x43 then 0x44.
- Low glitch of 100 clocks on idle line → `busy` pulses, no `WR_RX`, no `frame_err`, `dataRX` unchanged.
- Frame 0x42 with stop bit forced 0, line held low for 5000 clocks, then 0x41 → one `frame_err`, no `WR_RX` during the low period, then `dataRX` = 0x41 with `WR_RX`.
- Assert `rstn` low during data bit 4 of 0x44, release, send 0x41 → all outputs 0 during reset, no strobe for the aborted frame, then `dataRX` = 0x41.
- With `UART_RX_PARITY_EN`: send 0x41 with odd parity bit → `frame_err` pulse, `dataRX` keeps prior value. Correct parity → `WR_RX`, `dataRX` = 0x41.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver.
// The optional UART_RX_PARITY_EN macro is consumed by uart_rx.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } state_e;

  localparam int DEFAULT_CLK_FREQ = 31500000;
  localparam int DEFAULT_BAUD     = 115200;

  function automatic int calc_clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line; resets to the idle (high) level.
module uart_rx_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver producing a byte plus one-cycle write strobe for the game core.
// Define UART_RX_PARITY_EN for 8E1 framing; default build is 8N1.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ     = DEFAULT_CLK_FREQ,
  parameter int BAUD         = DEFAULT_BAUD,
  parameter int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD)
) (
  input  logic       px_clk,
  input  logic       rstn,
  input  logic       rx,
  output logic [7:0] dataRX,
  output logic       WR_RX,
  output logic       frame_err,
  output logic       busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic rxs;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             wr_q, wr_d;
  logic             ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
  logic             par_err_q, par_err_d;
`endif

  uart_rx_sync u_sync (
    .clk_i  (px_clk),
    .rst_ni (rstn),
    .d_i    (rx),
    .q_o    (rxs)
  );

  always_ff @(posedge px_clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      wr_q      <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      wr_q      <= wr_d;
      ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_err_q <= par_err_d;
`endif
    end
  end

  // clk_cnt restarts at zero on every state entry and after each bit sample.
  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q + 1'b1;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    wr_d      = 1'b0;
    ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_err_d = par_err_q;
`endif

    case (state_q)
      IDLE: begin
        clk_cnt_d = '0;
        if (!rxs) state_d = START;
      end

      START: begin
        if (clk_cnt_q == HALF_LAST) begin
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          state_d   = rxs ? IDLE : DATA;
        end
      end

      DATA: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          shift_d   = {rxs, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          par_err_d = ^{shift_q, rxs};
          state_d   = STOP;
        end
      end
`endif

      STOP: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          state_d   = IDLE;
          if (!rxs) begin
            // A low stop bit may be a held break; park until the line recovers.
            ferr_d  = 1'b1;
            state_d = BREAK;
`ifdef UART_RX_PARITY_EN
          end else if (par_err_q) begin
            ferr_d = 1'b1;
`endif
          end else begin
            data_d = shift_q;
            wr_d   = 1'b1;
          end
        end
      end

      BREAK: begin
        clk_cnt_d = '0;
        if (rxs) state_d = IDLE;
      end

      default: begin
        clk_cnt_d = '0;
        state_d   = IDLE;
      end
    endcase
  end

  assign dataRX    = data_q;
  assign WR_RX     = wr_q;
  assign frame_err = ferr_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at default parameters (273 clocks per bit).
// Define UART_RX_PARITY_EN for both bench and RTL to exercise 8E1 framing.
module tb_uart_rx;

  localparam int CPB = 273;
`ifdef UART_RX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  // Pin change at cycle N -> strobe visible at N + 2 (sync) + CPB/2 + (9+parity)*CPB + 1.
  localparam int WR_OFFSET = 2 + CPB / 2 + (9 + PAR_BITS) * CPB + 1;

  logic       px_clk = 1'b0;
  logic       rstn   = 1'b0;
  logic       rx     = 1'b1;
  logic [7:0] dataRX;
  logic       WR_RX;
  logic       frame_err;
  logic       busy;

  int cyc       = 0;
  int checks    = 0;
  int errors    = 0;
  int wrCount   = 0;
  int ferrCount = 0;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } expT;

  expT expQ[$];
  expT popped;

  uart_rx dut (
    .px_clk    (px_clk),
    .rstn      (rstn),
    .rx        (rx),
    .dataRX    (dataRX),
    .WR_RX     (WR_RX),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 px_clk = ~px_clk;

  always @(posedge px_clk) cyc <= cyc + 1;

  // Scoreboard: every strobe must match the oldest expected byte and cycle.
  always @(negedge px_clk) begin
    if (rstn) begin
      if (frame_err) ferrCount++;
      if (WR_RX) begin
        wrCount++;
        checks++;
        if (frame_err) begin
          errors++;
          $display("[TB] FAIL wr_and_ferr: WR_RX=%b frame_err=%b, required not both high", WR_RX, frame_err);
        end
        checks++;
        if (expQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_wr: strobe at cycle %0d with data 0x%02h, required no strobe", cyc, dataRX);
        end else begin
          popped = expQ.pop_front();
          checks++;
          if (dataRX !== popped.data) begin
            errors++;
            $display("[TB] FAIL wr_data: got 0x%02h, expected 0x%02h", dataRX, popped.data);
          end
          checks++;
          if (cyc !== popped.cyc) begin
            errors++;
            $display("[TB] FAIL wr_cycle: got %0d, expected %0d", cyc, popped.cyc);
          end
        end
      end
    end
  end

  initial begin
    #(400000 * 10);
    $display("[TB] FAIL watchdog: simulation still running at cycle %0d, required completion", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic align();
    @(posedge px_clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (CPB) @(posedge px_clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge px_clk);
    #1;
  endtask

  // Must be called right after align() or a previous frame so cyc marks the start edge.
  task automatic send_frame(input logic [7:0] d, input logic stopBit,
                            input logic badParity, input logic expectGood);
    expT e;
    if (expectGood) begin
      e.data = d;
      e.cyc  = cyc + WR_OFFSET;
      expQ.push_back(e);
    end
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ badParity);
`else
    if (badParity) $display("[TB] note: parity flip has no effect in the 8N1 build");
`endif
    drive_bit(stopBit);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    rx   = 1'b1;
    repeat (3) @(negedge px_clk);
    checks++;
    if (dataRX !== 8'h00) begin errors++; $display("[TB] FAIL reset_data: got 0x%02h, expected 0x00", dataRX); end
    checks++;
    if (WR_RX !== 1'b0) begin errors++; $display("[TB] FAIL reset_wr: got %b, expected 0", WR_RX); end
    checks++;
    if (frame_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_ferr: got %b, expected 0", frame_err); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b, expected 0", busy); end
    align();
    rstn = 1'b1;
    idle(10);
  endtask

  task automatic test_single();
    int wr0 = wrCount;
    int fe0 = ferrCount;
    align();
    send_frame(8'h41, 1'b1, 1'b0, 1'b1);
    idle(CPB);
    checks++;
    if (wrCount - wr0 !== 1) begin errors++; $display("[TB] FAIL single_wr_count: got %0d, expected 1", wrCount - wr0); end
    checks++;
    if (ferrCount - fe0 !== 0) begin errors++; $display("[TB] FAIL single_ferr: got %0d, expected 0", ferrCount - fe0); end
    checks++;
    if (expQ.size() !== 0) begin errors++; $display("[TB] FAIL single_pending: got %0d, expected 0", expQ.size()); expQ.delete(); end
    checks++;
    if (dataRX !== 8'h41) begin errors++; $display("[TB] FAIL single_data: got 0x%02h, expected 0x41", dataRX); end
  endtask

  task automatic test_back_to_back();
    int wr0 = wrCount;
    align();
    send_frame(8'h43, 1'b1, 1'b0, 1'b1);
    send_frame(8'h44, 1'b1, 1'b0, 1'b1);
    idle(CPB);
    checks++;
    if (wrCount - wr0 !== 2) begin errors++; $display("[TB] FAIL b2b_wr_count: got %0d, expected 2", wrCount - wr0); end
    checks++;
    if (expQ.size() !== 0) begin errors++; $display("[TB] FAIL b2b_pending: got %0d, expected 0", expQ.size()); expQ.delete(); end
    checks++;
    if (dataRX !== 8'h44) begin errors++; $display("[TB] FAIL b2b_data: got 0x%02h, expected 0x44", dataRX); end
  endtask

  task automatic test_glitch();
    int wr0 = wrCount;
    int fe0 = ferrCount;
    align();
    rx = 1'b0;
    repeat (50) @(negedge px_clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("[TB] FAIL glitch_busy_high: got %b, expected 1", busy); end
    repeat (50) @(posedge px_clk);
    #1;
    idle(2 * CPB);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL glitch_busy_low: got %b, expected 0", busy); end
    checks++;
    if (wrCount - wr0 !== 0 || ferrCount - fe0 !== 0) begin
      errors++;
      $display("[TB] FAIL glitch_flags: wr=%0d ferr=%0d, expected 0 and 0", wrCount - wr0, ferrCount - fe0);
    end
    checks++;
    if (dataRX !== 8'h44) begin errors++; $display("[TB] FAIL glitch_data: got 0x%02h, expected 0x44", dataRX); end
  endtask

  task automatic test_break();
    int wr0 = wrCount;
    int fe0 = ferrCount;
    align();
    send_frame(8'h42, 1'b0, 1'b0, 1'b0);
    rx = 1'b0;
    repeat (5000) @(posedge px_clk);
    #1;
    checks++;
    if (ferrCount - fe0 !== 1) begin errors++; $display("[TB] FAIL break_ferr_count: got %0d, expected 1", ferrCount - fe0); end
    checks++;
    if (wrCount - wr0 !== 0) begin errors++; $display("[TB] FAIL break_wr_count: got %0d, expected 0", wrCount - wr0); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("[TB] FAIL break_busy: got %b, expected 1", busy); end
    checks++;
    if (dataRX !== 8'h44) begin errors++; $display("[TB] FAIL break_data_held: got 0x%02h, expected 0x44", dataRX); end
    idle(2 * CPB);
    send_frame(8'h41, 1'b1, 1'b0, 1'b1);
    idle(CPB);
    checks++;
    if (wrCount - wr0 !== 1) begin errors++; $display("[TB] FAIL break_recover_wr: got %0d, expected 1", wrCount - wr0); end
    checks++;
    if (dataRX !== 8'h41) begin errors++; $display("[TB] FAIL break_recover_data: got 0x%02h, expected 0x41", dataRX); end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] d = 8'h44;
    int wr0 = wrCount;
    int fe0 = ferrCount;
    align();
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    rx = d[4];
    repeat (CPB / 2) @(posedge px_clk);
    #1;
    rstn = 1'b0;
    repeat (3) @(negedge px_clk);
    checks++;
    if (dataRX !== 8'h00 || WR_RX !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_outputs: data=0x%02h wr=%b ferr=%b busy=%b, expected all 0",
               dataRX, WR_RX, frame_err, busy);
    end
    rx = 1'b1;
    repeat (10) @(posedge px_clk);
    #1;
    rstn = 1'b1;
    idle(3 * CPB);
    checks++;
    if (wrCount - wr0 !== 0 || ferrCount - fe0 !== 0) begin
      errors++;
      $display("[TB] FAIL midreset_no_strobe: wr=%0d ferr=%0d, expected 0 and 0", wrCount - wr0, ferrCount - fe0);
    end
    send_frame(8'h41, 1'b1, 1'b0, 1'b1);
    idle(CPB);
    checks++;
    if (dataRX !== 8'h41) begin errors++; $display("[TB] FAIL midreset_data: got 0x%02h, expected 0x41", dataRX); end
    checks++;
    if (expQ.size() !== 0) begin errors++; $display("[TB] FAIL midreset_pending: got %0d, expected 0", expQ.size()); expQ.delete(); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int wr0;
    int fe0;
    align();
    send_frame(8'h43, 1'b1, 1'b0, 1'b1);
    idle(CPB);
    wr0 = wrCount;
    fe0 = ferrCount;
    send_frame(8'h41, 1'b1, 1'b1, 1'b0);
    idle(CPB);
    checks++;
    if (ferrCount - fe0 !== 1) begin errors++; $display("[TB] FAIL parity_ferr: got %0d, expected 1", ferrCount - fe0); end
    checks++;
    if (wrCount - wr0 !== 0) begin errors++; $display("[TB] FAIL parity_no_wr: got %0d, expected 0", wrCount - wr0); end
    checks++;
    if (dataRX !== 8'h43) begin errors++; $display("[TB] FAIL parity_data_held: got 0x%02h, expected 0x43", dataRX); end
    send_frame(8'h41, 1'b1, 1'b0, 1'b1);
    idle(CPB);
    checks++;
    if (dataRX !== 8'h41) begin errors++; $display("[TB] FAIL parity_good_data: got 0x%02h, expected 0x41", dataRX); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_break();
    test_reset_midframe();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    checks++;
    if (expQ.size() !== 0) begin
      errors++;
      $display("[TB] FAIL final_pending: got %0d outstanding, expected 0", expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
